// File: rtl/pwm_audio_out.sv
// Sample FIFO plus 2^DATA_W-cycle PWM replay. One sample is popped per frame; pwm_out is registered (1 cycle behind pwm_cnt).
// No backpressure: s_ready is advisory only, and a sample arriving while the FIFO is full is dropped and sets sticky overflow.

module pwm_sample_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push_vld,
   input  logic [W-1:0]     push_dat,
   input  logic             pop_vld,
   output logic [W-1:0]     pop_dat,
   output logic             full,
   output logic [LVL_W-1:0] level
);
   localparam int AW = LVL_W - 1;
   localparam logic [LVL_W-1:0] PTR_ONE = LVL_W'(1);

   logic [W-1:0]     mem [DEPTH];
   logic [LVL_W-1:0] wr_ptr;
   logic [LVL_W-1:0] rd_ptr;

   // Extra pointer MSB separates full from empty when the address bits match.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_vld) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_vld)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld) mem[wr_ptr[AW-1:0]] <= push_dat;
   end

   assign pop_dat = mem[rd_ptr[AW-1:0]];
   assign level   = wr_ptr - rd_ptr;
   assign full    = (level == LVL_W'(DEPTH));
endmodule

module pwm_audio_out #(
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int PRIME_LEVEL = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [DATA_W-1:0]             s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic                          pwm_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun,
   output logic                          overflow
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DATA_W-1:0] MIDSCALE  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] CNT_LAST  = '1;
   localparam logic [DATA_W-1:0] CNT_ONE   = DATA_W'(1);
   localparam logic [LVL_W-1:0]  PRIME_LVL = LVL_W'(PRIME_LEVEL);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t            state_q;
   state_t            state_d;
   logic [DATA_W-1:0] pwm_cnt;
   logic [DATA_W-1:0] duty;
   logic [DATA_W-1:0] head_dat;
   logic              fifo_full;
   logic              push_vld;
   logic              drop_vld;
   logic              pop_vld;
   logic              load_mid;
   logic              frame_end;

   assign frame_end = (state_q != IDLE) && (pwm_cnt == CNT_LAST);
   assign push_vld  = enable && s_valid && !fifo_full;
   assign drop_vld  = enable && s_valid && fifo_full;
   assign s_ready   = !fifo_full;

   pwm_sample_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH),
      .LVL_W (LVL_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (!enable),
      .push_vld (push_vld),
      .push_dat (s_data),
      .pop_vld  (pop_vld),
      .pop_dat  (head_dat),
      .full     (fifo_full),
      .level    (fifo_level)
   );

   always_comb begin
      state_d  = state_q;
      pop_vld  = 1'b0;
      load_mid = 1'b0;
      underrun = 1'b0;
      case (state_q)
         IDLE:  state_d = PRIME;
         PRIME: begin
            if (frame_end && (fifo_level >= PRIME_LVL)) begin
               pop_vld = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (frame_end) begin
               if (fifo_level != '0) begin
                  pop_vld = 1'b1;
               end else begin
                  underrun = 1'b1;
                  load_mid = 1'b1;
                  state_d  = PRIME;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Disable overrides everything: no pop, no pulse, back to IDLE.
      if (!enable) begin
         state_d  = IDLE;
         pop_vld  = 1'b0;
         load_mid = 1'b0;
         underrun = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         pwm_cnt  <= '0;
         duty     <= MIDSCALE;
         pwm_out  <= 1'b0;
         overflow <= 1'b0;
      end else begin
         state_q <= state_d;
         pwm_out <= enable && (state_q != IDLE) && (pwm_cnt < duty);
         if (!enable || (state_q == IDLE)) pwm_cnt <= '0;
         else                              pwm_cnt <= pwm_cnt + CNT_ONE;
         if (!enable || load_mid) duty <= MIDSCALE;
         else if (pop_vld)        duty <= head_dat;
         if (!enable)       overflow <= 1'b0;
         else if (drop_vld) overflow <= 1'b1;
      end
   end
endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Playback output stage; sits directly downstream of the capture/playback top level.
- Consumes 8-bit unsigned amplitude samples delivered as single-cycle strobes at the decimated sample rate, and buffers them in a small FIFO.
- Replays one sample per PWM frame as a single-bit PWM audio output suitable for an RC low-pass filter and amplifier.
- Manages priming, underrun (midscale silence) and overflow, so bursty or early samples do not glitch the output.

Parameters:
- DATA_W, 8, sample width; the PWM frame is 2^DATA_W clk cycles (256 cycles, 171.875 kHz at 44 MHz).
- FIFO_DEPTH, 16, sample FIFO entries; power of two, ≥4.
- PRIME_LEVEL, 8, FIFO occupancy required to leave PRIME.

Ports:
- clk  in  1  system clock (44 MHz).
- reset  in  1  synchronous, active-high reset.
- enable  in  1  playback enable; low flushes and idles the block.
- s_data  in  DATA_W  unsigned sample (0x80 = midscale/silence).
- s_valid  in  1  one-cycle strobe; s_data is captured on this cycle.
- s_ready  out  1  = !fifo_full; advisory only, because the upstream stage does not stall.
- pwm_out  out  1  registered PWM output.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.
- underrun  out  1  one-cycle pulse when a frame boundary in RUN finds the FIFO empty.
- overflow  out  1  sticky; set when a sample is dropped.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high.
- Reset values:
  - State = IDLE; FIFO empty.
  - fifo_level = 0; s_ready = 1.
  - pwm_cnt = 0; duty = 0x80.
  - pwm_out = 0; underrun = 0; overflow = 0.
- Reset mid-frame or mid-burst discards all FIFO contents immediately.
- FIFO push:
  - On s_valid && !full: write s_data and increment level.
  - On s_valid && full: drop the sample and set overflow. This applies even if a pop occurs on the same cycle.
- FIFO pop: occurs only at a frame boundary, as defined below.
  - Push and pop on the same cycle with !full: both happen and level is unchanged.
  - Push into an empty FIFO is not visible to a pop on the same cycle.
- Frame boundary: the cycle where pwm_cnt == 2^DATA_W-1. pwm_cnt increments every cycle in PRIME and RUN and wraps to 0.
- States:
  - IDLE:
    - pwm_cnt held at 0; pwm_out = 0.
    - FIFO accepts pushes.
    - enable=1 → PRIME on the next cycle.
  - PRIME:
    - duty = 0x80, so the output is 50% duty (silence).
    - At a frame boundary with level ≥ PRIME_LEVEL: pop the head into duty and go to RUN.
  - RUN:
    - At each frame boundary, level > 0: pop the head into duty.
    - At a frame boundary, level == 0: set duty = 0x80, pulse underrun for that cycle, and go to PRIME.
  - Any state with enable=0 → IDLE on the next cycle:
    - FIFO flushed; level = 0.
    - overflow cleared.
    - duty = 0x80; pwm_cnt = 0.
- PWM output:
  - pwm_out <= (pwm_cnt < duty), evaluated in PRIME and RUN and registered, so pwm_out lags pwm_cnt by one cycle.
  - The new duty takes effect at pwm_cnt = 0 and is seen on pwm_out one cycle later.
  - duty 0x00 → pwm_out low for the whole frame.
  - duty 0xFF → high for 255 of 256 cycles.
  - duty 0x80 → exactly 128 high cycles per frame.
- Widths:
  - pwm_cnt is DATA_W bits unsigned and wraps naturally.
  - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits, with the MSB distinguishing full from empty.
- Outputs:
  - fifo_level and s_ready reflect the registered state; they update one cycle after a push or pop.
  - underrun is never asserted in IDLE or PRIME.

Test Plan:
- Reset/idle: assert reset 3 cycles, enable=0 → pwm_out=0, fifo_level=0, s_ready=1, overflow=0, underrun=0.
- Priming and playback:
  - Stimulus: enable=1, push 8 samples 0x00,0x40,0x80,0xC0,0xFF,0x10,0x20,0x30 spaced 64 cycles apart.
  - Before the first frame boundary with level ≥ 8: 128-high/128-low frames.
  - After that: the next frames show high counts of 0, 64, 128, 192, 255, 16, 32, 48.
  - Level decrements by 1 per frame.
- Underrun:
  - Stimulus: continue the playback test with no further pushes.
  - At the frame boundary after the last sample: a one-cycle underrun pulse, then 128-high frames.
  - The state returns to PRIME; no further pops until level ≥ 8.
- Overflow:
  - Stimulus: enable=1, push 20 samples back-to-back (1/cycle) within one frame.
  - Level saturates at 16, s_ready=0, and overflow=1 from the 17th push onward.
  - The popped sequence matches the first 16 samples.
- Simultaneous push/pop: with level=5 in RUN, assert s_valid exactly on the frame-boundary cycle → level stays 5 and the popped value is the old head.
- Mid-operation disable:
  - Stimulus: in RUN with level=6 and overflow=1, drop enable for 1 cycle then reassert.
  - Response: IDLE with pwm_out=0, level=0, overflow=0, then PRIME with 128-high frames.
  - Repeat with reset instead of enable → same result.
